// File: rtl/npc_sequencer_pkg.sv
// Shared SPARC sequencing definitions: sequencer state, Bicc cond codes, reset PC.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package sparc_pkg;

   localparam int ADDR_W = 32;

   typedef enum logic [0:0] {
      EXEC   = 1'b0,
      SQUASH = 1'b1
   } seq_state_t;

   localparam logic [3:0]        COND_BA          = 4'b1000;
   localparam logic [3:0]        COND_BN          = 4'b0000;
   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] INSTR_BYTES      = 32'd4;

   // Instructions are always word sized, so any address with low bits set is illegal.
   function automatic logic word_aligned(input logic [ADDR_W-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/npc_sequencer_if.sv
// Decode-to-sequencer bundle: CTI decode fields in, pc/npc/squash/align_err out.
// Latency: wires only.
// Backpressure: carried by stall / instr_valid inside the bundle.
// master = decode side (drives instruction fields), slave = sequencer.
interface npc_sequencer_if;
   import sparc_pkg::*;

   logic              stall;
   logic              instr_valid;
   logic              is_bicc;
   logic [3:0]        cond;
   logic              annul_bit;
   logic              cond_true;
   logic [21:0]       disp22;
   logic              is_call;
   logic [29:0]       disp30;
   logic              is_jmpl;
   logic [ADDR_W-1:0] jmpl_target;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] npc;
   logic              squash;
   logic              align_err;

   modport master (
      output stall, instr_valid, is_bicc, cond, annul_bit, cond_true, disp22,
             is_call, disp30, is_jmpl, jmpl_target,
      input  pc, npc, squash, align_err
   );

   modport slave (
      input  stall, instr_valid, is_bicc, cond, annul_bit, cond_true, disp22,
             is_call, disp30, is_jmpl, jmpl_target,
      output pc, npc, squash, align_err
   );

endinterface

// File: rtl/npc_sequencer_branch_target_adder.sv
// PC-relative target: pc + (CALL ? disp30<<2 : sext(disp22)<<2), modulo 2^32.
// Latency: combinational.
// Backpressure: none.
// Ports: pc (current pc), sel_call (1 = CALL displacement), disp22, disp30, target.
module branch_target_adder
   import sparc_pkg::*;
(
   input  logic [ADDR_W-1:0] pc,
   input  logic              sel_call,
   input  logic [21:0]       disp22,
   input  logic [29:0]       disp30,
   output logic [ADDR_W-1:0] target
);

   logic [ADDR_W-1:0] offset;

   // disp30 fills the whole word after the shift, so it needs no sign extension.
   assign offset = sel_call ? {disp30, 2'b00} : {{8{disp22[21]}}, disp22, 2'b00};
   assign target = pc + offset;

endmodule

// File: rtl/npc_sequencer.sv
// SPARC pc/npc sequencer with delayed branches, annul (SQUASH) and JMPL alignment check.
// Latency: pc/npc/state registered, move one cycle after an advancing instruction; squash/align_err combinational.
// Backpressure: stall=1 or instr_valid=0 holds pc, npc and state; reset overrides everything.
// Ports: clk, reset (sync, active high), bus (npc_sequencer_if.slave: decode fields in, pc/npc/squash/align_err out).
module npc_sequencer
   import sparc_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic           clk,
   input  logic           reset,
   npc_sequencer_if.slave bus
);

   seq_state_t        state;
   seq_state_t        state_next;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] npc_q;
   logic [ADDR_W-1:0] npc_next;
   logic [ADDR_W-1:0] npc_seq;
   logic [ADDR_W-1:0] target;
   logic              advance;
   logic              jmpl_misaligned;

   assign advance = !bus.stall && bus.instr_valid;
   assign npc_seq = npc_q + INSTR_BYTES;

   branch_target_adder u_target (
      .pc       (pc_q),
      .sel_call (bus.is_call),
      .disp22   (bus.disp22),
      .disp30   (bus.disp30),
      .target   (target)
   );

   // Next-state / next-npc. Priority JMPL > CALL > Bicc. In SQUASH the
   // instruction at pc is annulled, so its CTI flags are ignored and the
   // defaults (sequential npc, back to EXEC) apply.
   always_comb begin
      state_next      = EXEC;
      npc_next        = npc_seq;
      jmpl_misaligned = 1'b0;
      if (state == EXEC) begin
         if (bus.is_jmpl) begin
            if (word_aligned(bus.jmpl_target)) begin
               npc_next = bus.jmpl_target;
            end else begin
               jmpl_misaligned = 1'b1;
            end
         end else if (bus.is_call) begin
            npc_next = target;
         end else if (bus.is_bicc) begin
            if (bus.cond == COND_BA) begin
               // BA with a=1 annuls its own delay slot even though it is taken.
               npc_next = target;
               if (bus.annul_bit) begin
                  state_next = SQUASH;
               end
            end else if (bus.cond_true && (bus.cond != COND_BN)) begin
               // Taken conditional branch: delay slot always executes.
               npc_next = target;
            end else if (bus.annul_bit) begin
               state_next = SQUASH;
            end
         end
      end
   end

   // A misaligned JMPL traps instead of retiring, so nothing moves that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         npc_q <= RESET_PC + INSTR_BYTES;
         state <= EXEC;
      end else if (advance && !jmpl_misaligned) begin
         pc_q  <= npc_q;
         npc_q <= npc_next;
         state <= state_next;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.npc       = npc_q;
   assign bus.squash    = (state == SQUASH);
   assign bus.align_err = advance && jmpl_misaligned && !reset;

endmodule

// File: tb/tb_npc_sequencer.sv
// Bench for npc_sequencer: directed vector table, hand-written multi-cycle sequences,
// and a randomized run against an architectural pc/npc/annul model.
// Outputs are sampled 3 time units after the active edge, inputs driven 1 unit after it.
module tb_npc_sequencer;
   import sparc_pkg::*;

   localparam int K_PLAIN = 0;
   localparam int K_BICC  = 1;
   localparam int K_CALL  = 2;
   localparam int K_JMPL  = 3;
   localparam int K_STALL = 4;
   localparam int K_NOVLD = 5;
   localparam int K_ALL   = 6;

   typedef struct {
      logic        stall;
      logic        vld;
      logic        bicc;
      logic [3:0]  cond;
      logic        a;
      logic        ct;
      logic [21:0] d22;
      logic        call;
      logic [29:0] d30;
      logic        jmpl;
      logic [31:0] jt;
      logic [31:0] e_pc;
      logic [31:0] e_npc;
      logic        e_sq;
      logic        e_ae;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   npc_sequencer_if bus ();

   npc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [31:0] p, input logic [31:0] n,
                                input logic sq, input logic ae);
      check($sformatf("%s pc", tag), bus.pc, p);
      check($sformatf("%s npc", tag), bus.npc, n);
      check($sformatf("%s squash", tag), 32'(bus.squash), 32'(sq));
      check($sformatf("%s align_err", tag), 32'(bus.align_err), 32'(ae));
   endtask

   function automatic vec_t mk(input int kind, input logic [3:0] cond, input logic a,
                               input logic ct, input logic [31:0] arg,
                               input logic [31:0] p, input logic [31:0] n,
                               input logic sq, input logic ae);
      vec_t v;
      v.stall = 1'b0; v.vld = 1'b1; v.bicc = 1'b0; v.call = 1'b0; v.jmpl = 1'b0;
      v.cond = cond; v.a = a; v.ct = ct;
      v.d22 = arg[21:0]; v.d30 = arg[29:0]; v.jt = arg;
      v.e_pc = p; v.e_npc = n; v.e_sq = sq; v.e_ae = ae;
      case (kind)
         K_BICC:  v.bicc = 1'b1;
         K_CALL:  v.call = 1'b1;
         K_JMPL:  v.jmpl = 1'b1;
         K_STALL: begin v.stall = 1'b1; v.jmpl = 1'b1; end
         K_NOVLD: begin v.vld = 1'b0; v.call = 1'b1; end
         K_ALL:   begin v.jmpl = 1'b1; v.call = 1'b1; v.bicc = 1'b1; end
         default: ;
      endcase
      return v;
   endfunction

   task automatic apply(input vec_t v);
      bus.stall = v.stall; bus.instr_valid = v.vld; bus.is_bicc = v.bicc;
      bus.cond = v.cond; bus.annul_bit = v.a; bus.cond_true = v.ct;
      bus.disp22 = v.d22; bus.is_call = v.call; bus.disp30 = v.d30;
      bus.is_jmpl = v.jmpl; bus.jmpl_target = v.jt;
   endtask

   task automatic drive_plain();
      apply(mk(K_PLAIN, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[$];
      logic [31:0] m_pc, m_npc, jt, off32;
      logic [21:0] d22;
      logic [29:0] d30;
      logic [3:0]  cond;
      bit          m_annul, r, stl, vld, bicc, call, jmpl, a, ct, adv, taken, exp_ae;
      int          off;

      // PC walk starts at 0 and visits 0x100 / 0x200 / 0x3000 for the directed cases.
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h0,    32'h4,    0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h4,    32'h8,    0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h8,    32'hC,    0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'hC,    32'h10,   0, 0));
      vecs.push_back(mk(K_CALL,  4'h0, 0, 0, 32'h3C,     32'h10,   32'h14,   0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h14,   32'h100,  0, 0));
      vecs.push_back(mk(K_BICC,  4'h1, 0, 1, 32'h10,     32'h100,  32'h104,  0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h104,  32'h140,  0, 0));
      vecs.push_back(mk(K_JMPL,  4'h0, 0, 0, 32'h100,    32'h140,  32'h144,  0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h144,  32'h100,  0, 0));
      vecs.push_back(mk(K_BICC,  4'h1, 1, 0, 32'h10,     32'h100,  32'h104,  0, 0));
      vecs.push_back(mk(K_CALL,  4'h0, 0, 0, 32'h3FFF,   32'h104,  32'h108,  1, 0));
      vecs.push_back(mk(K_JMPL,  4'h0, 0, 0, 32'h100,    32'h108,  32'h10C,  0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h10C,  32'h100,  0, 0));
      vecs.push_back(mk(K_BICC,  4'h8, 1, 0, 32'h3FFFFC, 32'h100,  32'h104,  0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h104,  32'hF0,   1, 0));
      vecs.push_back(mk(K_CALL,  4'h0, 0, 0, 32'h44,     32'hF0,   32'hF4,   0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'hF4,   32'h200,  0, 0));
      vecs.push_back(mk(K_JMPL,  4'h0, 0, 0, 32'h2002,   32'h200,  32'h204,  0, 1));
      vecs.push_back(mk(K_JMPL,  4'h0, 0, 0, 32'h3000,   32'h200,  32'h204,  0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h204,  32'h3000, 0, 0));
      vecs.push_back(mk(K_STALL, 4'h0, 0, 0, 32'h2,      32'h3000, 32'h3004, 0, 0));
      vecs.push_back(mk(K_NOVLD, 4'h0, 0, 0, 32'h10,     32'h3000, 32'h3004, 0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h3000, 32'h3004, 0, 0));
      vecs.push_back(mk(K_JMPL,  4'h0, 0, 0, 32'h500,    32'h3004, 32'h3008, 0, 0));
      vecs.push_back(mk(K_CALL,  4'h0, 0, 0, 32'h10,     32'h3008, 32'h500,  0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h500,  32'h3048, 0, 0));
      vecs.push_back(mk(K_ALL,   4'h8, 1, 0, 32'h800,    32'h3048, 32'h304C, 0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h304C, 32'h800,  0, 0));
      vecs.push_back(mk(K_BICC,  4'h0, 1, 1, 32'h10,     32'h800,  32'h804,  0, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h804,  32'h808,  1, 0));
      vecs.push_back(mk(K_PLAIN, 4'h0, 0, 0, 32'h0,      32'h808,  32'h80C,  0, 0));

      reset = 1'b1;
      drive_plain();
      tick();
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
         #2;
         check_outputs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_npc, vecs[i].e_sq, vecs[i].e_ae);
         tick();
      end

      // Untaken annulling Bicc, stall through SQUASH, then reset discards it.
      apply(mk(K_BICC, 4'h1, 1, 0, 32'h10, 32'h0, 32'h0, 0, 0));
      #2;
      check_outputs("sq_enter", 32'h80C, 32'h810, 1'b0, 1'b0);
      tick();
      for (int s = 0; s < 3; s++) begin
         apply(mk(K_STALL, 4'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0));
         #2;
         check_outputs($sformatf("sq_stall%0d", s), 32'h810, 32'h814, 1'b1, 1'b0);
         tick();
      end
      reset = 1'b1;
      apply(mk(K_STALL, 4'h0, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0));
      tick();
      reset = 1'b0;
      drive_plain();
      #2;
      check_outputs("sq_reset", 32'h0, 32'h4, 1'b0, 1'b0);

      // Reset must mask align_err even with a misaligned JMPL presented in EXEC.
      reset = 1'b1;
      apply(mk(K_JMPL, 4'h0, 0, 0, 32'h1001, 32'h0, 32'h0, 0, 0));
      #1;
      check("rst_align_err", 32'(bus.align_err), 32'h0);
      tick();
      reset = 1'b0;
      drive_plain();
      #2;
      check_outputs("rst_jmpl", 32'h0, 32'h4, 1'b0, 1'b0);
      tick();

      // Randomized run against the architectural model.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_pc = 32'h0; m_npc = 32'h4; m_annul = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         r    = ($urandom_range(49) == 0);
         stl  = ($urandom_range(5) == 0);
         vld  = ($urandom_range(5) != 0);
         bicc = ($urandom_range(1) == 0);
         call = ($urandom_range(4) == 0);
         jmpl = ($urandom_range(4) == 0);
         cond = 4'($urandom_range(15));
         if ($urandom_range(3) == 0) cond = COND_BA;
         a    = ($urandom_range(1) == 0);
         ct   = ($urandom_range(1) == 0);
         d22  = 22'($urandom);
         d30  = 30'($urandom);
         jt   = $urandom;
         if ($urandom_range(3) != 0) jt[1:0] = 2'b00;

         reset = r;
         bus.stall = stl; bus.instr_valid = vld; bus.is_bicc = bicc; bus.cond = cond;
         bus.annul_bit = a; bus.cond_true = ct; bus.disp22 = d22; bus.is_call = call;
         bus.disp30 = d30; bus.is_jmpl = jmpl; bus.jmpl_target = jt;

         adv    = !stl && vld;
         exp_ae = !r && adv && !m_annul && jmpl && (jt % 4 != 0);
         #2;
         check_outputs($sformatf("rand%0d", i), m_pc, m_npc, m_annul, exp_ae);

         if (r) begin
            m_pc = 32'h0; m_npc = 32'h4; m_annul = 1'b0;
         end else if (adv) begin
            if (m_annul) begin
               m_pc = m_npc; m_npc = m_npc + 4; m_annul = 1'b0;
            end else if (jmpl) begin
               if (jt % 4 == 0) begin
                  m_pc = m_npc; m_npc = jt;
               end
            end else if (call) begin
               off32 = m_pc + d30 * 4;
               m_pc = m_npc; m_npc = off32;
            end else if (bicc) begin
               off = int'(d22);
               if (off >= (1 << 21)) off = off - (1 << 22);
               off32 = m_pc + 32'(off * 4);
               taken = (cond == 4'b1000) || (ct && cond != 4'b0000);
               m_annul = a && (cond == 4'b1000 || !taken);
               m_pc = m_npc;
               m_npc = taken ? off32 : m_npc + 4;
            end else begin
               m_pc = m_npc; m_npc = m_npc + 4;
            end
         end
         tick();
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/npc_sequencer.md
NPC_SEQUENCER -- requirements
Module: npc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset; nPC resets to RESET_PC+4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  holds all state when high.
REQ-005 SHALL have port instr_valid  input  1  instruction at pc is present this cycle.
REQ-006 SHALL have port is_bicc  input  1  instruction is a Bicc.
REQ-007 SHALL have port cond  input  4  Bicc cond field.
REQ-008 SHALL have port annul_bit  input  1  Bicc 'a' bit.
REQ-009 SHALL have port cond_true  input  1  branch condition evaluated true against current icc.
REQ-010 SHALL have port disp22  input  22  Bicc word displacement.
REQ-011 SHALL have port is_call  input  1  instruction is CALL.
REQ-012 SHALL have port disp30  input  30  CALL word displacement.
REQ-013 SHALL have port is_jmpl  input  1  instruction is JMPL.
REQ-014 SHALL have port jmpl_target  input  32  computed JMPL address.
REQ-015 SHALL have port pc  output  32  address of current instruction.
REQ-016 SHALL have port npc  output  32  address of next instruction.
REQ-017 SHALL have port squash  output  1  instruction at pc is annulled; no architectural effect.
REQ-018 SHALL have port align_err  output  1  one-cycle pulse on misaligned JMPL target.

Function
REQ-019 SHALL implement states EXEC and SQUASH; reset state EXEC.
REQ-020 SHALL advance (pc<=npc, npc<=next) only on cycles with stall=0 and instr_valid=1; otherwise pc, npc, state hold.
REQ-021 In EXEC with no CTI: npc_next = npc+4, state stays EXEC.
REQ-022 Bicc target = pc + {sext(disp22),2'b00}; CALL target = pc + {disp30,2'b00}; all arithmetic modulo 2^32.
REQ-023 Bicc taken (cond_true=1, cond != BA): npc_next = target; delay slot executes; state EXEC.
REQ-024 Bicc BA (cond=4'b1000): npc_next = target regardless of cond_true; if annul_bit=1, state -> SQUASH.
REQ-025 Bicc untaken (cond_true=0 or cond=BN 4'b0000): npc_next = npc+4; if annul_bit=1, state -> SQUASH, else EXEC.
REQ-026 CALL: npc_next = CALL target; state EXEC.
REQ-027 JMPL with jmpl_target[1:0]=0: npc_next = jmpl_target; state EXEC.
REQ-028 JMPL with jmpl_target[1:0]!=0: pc, npc hold, align_err=1 for exactly that cycle, state EXEC.
REQ-029 In SQUASH: squash=1 combinationally; is_bicc/is_call/is_jmpl ignored; on advance npc_next = npc+4, state -> EXEC.
REQ-030 squash SHALL be 0 in EXEC.
REQ-031 If more than one of is_bicc/is_call/is_jmpl is high, priority JMPL > CALL > Bicc.
REQ-032 CTI in a delay slot (DCTI couple) SHALL follow REQ-021..027 unmodified (pc takes prior target, npc takes new target).
REQ-033 stall=1 in SQUASH SHALL keep squash=1 and state SQUASH.

Reset
REQ-034 On reset: pc=RESET_PC, npc=RESET_PC+4, state=EXEC, squash=0, align_err=0; reset overrides stall and all inputs.
REQ-035 Reset asserted mid-SQUASH SHALL discard the pending annul.

Structure
REQ-036 Shared package sparc_pkg SHALL hold state enum (EXEC, SQUASH), COND_BA=4'b1000, COND_BN=4'b0000, and the default reset PC constant.
REQ-037 Target computation SHALL be a sub-module branch_target_adder (pc, disp select, sign-extend, shift, add).

Verification
REQ-038 Reset, 3 plain instructions -> pc 0,4,8,12; npc 4,8,12,16; squash=0.
REQ-039 pc=0x100, Bicc cond=BE, cond_true=1, a=0, disp22=0x10 -> next pc=0x104 (slot, squash=0), then pc=0x140.
REQ-040 pc=0x100, Bicc untaken, a=1 -> pc=0x104 with squash=1, then pc=0x108 with squash=0.
REQ-041 pc=0x100, BA a=1, disp22=0x3FFFFC (-4) -> pc=0x104 squash=1, then pc=0xF0.
REQ-042 JMPL target 0x2002 at pc=0x200 -> align_err pulse 1 cycle, pc/npc stay 0x200/0x204; then JMPL 0x3000 -> pc=0x204, then 0x3000.
REQ-043 stall=1 for 3 cycles during SQUASH, then reset mid-SQUASH -> state holds squash=1 during stall; after reset pc=RESET_PC, squash=0.
